// File: rtl/pipe_pkg.sv
// Shared constants and write-back select encodings for the 8-bit pipeline.
package pipe_pkg;

    localparam int DW = 8;   // datapath width
    localparam int AW = 3;   // register address width
    localparam int CW = 16;  // retired-instruction counter width

    typedef enum logic [1:0] {
        WB_ADD = 2'b00,
        WB_MOV = 2'b01,
        WB_LDI = 2'b10,
        WB_SHL = 2'b11
    } wb_sel_t;

    // True for the selects that produce meaningful Z/C flags.
    function automatic logic sets_flags(input wb_sel_t sel);
        return (sel == WB_ADD) || (sel == WB_SHL);
    endfunction

endpackage

// File: rtl/regfile_8x8.sv
// Architectural register array: one synchronous write port with synchronous
// clear, two asynchronous read ports.
module regfile_8x8 #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    output logic [DW-1:0] rdata1,
    output logic [DW-1:0] rdata2
);

    localparam int NREGS = 1 << AW;

    logic [DW-1:0] mem [NREGS];

    // NOTE: every entry is cleared on reset, so this array maps to flops rather
    // than a RAM macro; the clear is part of the architectural reset state.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata1 = mem[raddr1];
    assign rdata2 = mem[raddr2];

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: forms the result, commits it to the register file, keeps
// Z/C flags and a retired count, and bypasses the commit to the ID read ports.
module wb_regfile
    import pipe_pkg::*;
#(
    parameter int DW = pipe_pkg::DW,
    parameter int AW = pipe_pkg::AW,
    parameter int CW = pipe_pkg::CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] data_a,
    input  logic [DW-1:0] data_b,
    input  logic [AW-1:0] rdst,
    input  logic [AW-1:0] imm_data,
    input  logic [1:0]    wb_sel,
    input  logic          status,
    input  logic [AW-1:0] rs1_addr,
    input  logic [AW-1:0] rs2_addr,
    output logic [DW-1:0] rs1_data,
    output logic [DW-1:0] rs2_data,
    output logic [DW-1:0] wb_result,
    output logic          flag_z,
    output logic          flag_c,
    output logic [CW-1:0] retired
);

    wb_sel_t       sel;
    logic [DW:0]   sum_w;
    logic [DW:0]   shl_w;
    logic [DW-1:0] res;
    logic          carry;
    logic [DW-1:0] rf_rd1;
    logic [DW-1:0] rf_rd2;

    assign sel   = wb_sel_t'(wb_sel);
    assign sum_w = {1'b0, data_a} + {1'b0, data_b};
    // The extra top bit catches the last bit shifted out; it stays 0 for imm 0.
    assign shl_w = {1'b0, data_a} << imm_data;

    // NOTE: outputs get defaults before the case so no latch is inferred.
    always_comb begin
        res   = '0;
        carry = 1'b0;
        case (sel)
            WB_ADD: begin
                res   = sum_w[DW-1:0];
                carry = sum_w[DW];
            end
            WB_MOV: res = data_a;
            WB_LDI: res = {{(DW-AW){1'b0}}, imm_data};
            WB_SHL: begin
                res   = shl_w[DW-1:0];
                carry = shl_w[DW];
            end
            default: ;
        endcase
    end

    assign wb_result = res;

    regfile_8x8 #(
        .DW(DW),
        .AW(AW)
    ) u_rf (
        .clk    (clk),
        .reset  (reset),
        .we     (status),
        .waddr  (rdst),
        .wdata  (res),
        .raddr1 (rs1_addr),
        .raddr2 (rs2_addr),
        .rdata1 (rf_rd1),
        .rdata2 (rf_rd2)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            flag_z  <= 1'b0;
            flag_c  <= 1'b0;
            retired <= '0;
        end else if (status) begin
            retired <= retired + CW'(1);
            if (sets_flags(sel)) begin
                flag_z <= (res == '0);
                flag_c <= carry;
            end
        end
    end

    // Same-cycle bypass so decode never sees the pre-commit value.
    assign rs1_data = (status && (rs1_addr == rdst)) ? res : rf_rd1;
    assign rs2_data = (status && (rs2_addr == rdst)) ? res : rf_rd2;

endmodule
